// File: rtl/mem_stage_hs.sv
// Memory pipeline stage between execute and writeback: registers execute results,
// drives a req/ack data bus with lane steering and formats load data.
module mem_stage_hs #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    localparam int NB = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_valid,
    input  logic [XLEN-1:0]   e_alu_result,
    input  logic [XLEN-1:0]   e_write_data,
    input  logic [RA_W-1:0]   e_rd,
    input  logic [XLEN-1:0]   e_pc_plus_4,
    input  logic              e_mem_read,
    input  logic              e_mem_write,
    input  logic [2:0]        e_funct3,
    output logic              m_stall,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [XLEN-1:0]   dbus_addr,
    output logic [XLEN-1:0]   dbus_wr_data,
    output logic [NB-1:0]     dbus_byte_en,
    input  logic              dbus_ack,
    input  logic [XLEN-1:0]   dbus_rd_data,
    output logic              m_valid,
    output logic [XLEN-1:0]   m_alu_result,
    output logic [XLEN-1:0]   m_load_data,
    output logic [RA_W-1:0]   m_rd,
    output logic [XLEN-1:0]   m_pc_plus_4,
    output logic              m_mem_fault
);

    localparam int OW = $clog2(NB);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic              valid_q;
    logic [XLEN-1:0]   aluResult_q;
    logic [XLEN-1:0]   writeData_q;
    logic [RA_W-1:0]   rd_q;
    logic [XLEN-1:0]   pcPlus4_q;
    logic              memRead_q;
    logic              memWrite_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   loadData_q, loadData_d;

    logic [OW-1:0]     offset;
    logic [OW+2:0]     shiftAmt;
    logic [NB-1:0]     sizeMask;
    logic [XLEN-1:0]   shiftedRd;
    logic [XLEN-1:0]   formatted;
    logic              captureStartsAccess;

    // Legal size code for this XLEN and naturally aligned for that size.
    function automatic logic accessOk(input logic [2:0] f3, input logic [OW-1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = (off[0] == 1'b0);
            3'b010:         ok = (off[1:0] == 2'b00);
            3'b110:         ok = (XLEN == 64) && (off[1:0] == 2'b00);
            3'b011:         ok = (XLEN == 64) && (off == '0);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign offset   = aluResult_q[OW-1:0];
    assign shiftAmt = {offset, 3'b000};

    always_comb begin
        sizeMask = '1;
        case (funct3_q[1:0])
            2'b00:   sizeMask = NB'(1);
            2'b01:   sizeMask = NB'(3);
            2'b10:   sizeMask = NB'(15);
            default: sizeMask = '1;
        endcase
    end

    assign shiftedRd = dbus_rd_data >> shiftAmt;

    always_comb begin
        formatted = '0;
        case (funct3_q)
            3'b000:  formatted = XLEN'($signed(shiftedRd[7:0]));
            3'b001:  formatted = XLEN'($signed(shiftedRd[15:0]));
            3'b010:  formatted = XLEN'($signed(shiftedRd[31:0]));
            3'b100:  formatted = XLEN'(shiftedRd[7:0]);
            3'b101:  formatted = XLEN'(shiftedRd[15:0]);
            3'b110:  formatted = XLEN'(shiftedRd[31:0]);
            3'b011:  formatted = shiftedRd;
            default: formatted = '0;
        endcase
    end

    assign captureStartsAccess = e_valid && (e_mem_read || e_mem_write)
                               && accessOk(e_funct3, e_alu_result[OW-1:0]);

    // A capture only happens in IDLE, so it also clears the previous load result.
    always_comb begin
        state_d    = state_q;
        loadData_d = loadData_q;
        case (state_q)
            IDLE: begin
                loadData_d = '0;
                if (captureStartsAccess) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dbus_ack) begin
                    state_d = IDLE;
                    if (memRead_q) begin
                        loadData_d = formatted;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            loadData_q <= '0;
        end else begin
            state_q    <= state_d;
            loadData_q <= loadData_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            aluResult_q <= '0;
            writeData_q <= '0;
            rd_q        <= '0;
            pcPlus4_q   <= '0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            funct3_q    <= '0;
        end else if (!m_stall) begin
            valid_q     <= e_valid;
            aluResult_q <= e_alu_result;
            writeData_q <= e_write_data;
            rd_q        <= e_rd;
            pcPlus4_q   <= e_pc_plus_4;
            memRead_q   <= e_valid && e_mem_read;
            memWrite_q  <= e_valid && e_mem_write;
            funct3_q    <= e_funct3;
        end
    end

    assign m_stall      = (state_q == WAIT);
    assign dbus_req     = (state_q == WAIT);
    assign dbus_we      = memWrite_q;
    assign dbus_addr    = aluResult_q;
    assign dbus_byte_en = sizeMask << offset;
    assign dbus_wr_data = writeData_q << shiftAmt;

    assign m_valid      = valid_q && (state_q == IDLE);
    assign m_alu_result = aluResult_q;
    assign m_load_data  = loadData_q;
    assign m_rd         = rd_q;
    assign m_pc_plus_4  = pcPlus4_q;
    assign m_mem_fault  = valid_q && (memRead_q || memWrite_q) && !accessOk(funct3_q, offset);

endmodule
